cpu_bus_arbiter: RTL
====================

// Module: cpu_bus_arbiter
// PURPOSE
// - Merges N_MASTERS CPU-side bus ports (I-fetch, D-load/store, later DMA/debug) onto one memory-side port.
// - Uses the core's ADDR/BURST/REQ/WRB/WDATA/RDATA/ACK/STALL/BSTROBE bus protocol.
// - Sits between the CPU top and the memory/interconnect. Replaces separate I and D buses on single-port memory builds.
// - Holds the grant for a whole transaction: a single beat or a BURST_LEN-beat INCR/WRAP burst.
// - Fixed-priority or round-robin arbitration; bus-timeout error reporting.
// PARAMETERS
// N_MASTERS  2   number of master ports (>=2)
// AW         32  address width
// DW         32  data width (multiple of 8)
// BURST_LEN  4   beats per INCR/WRAP burst (power of 2, >=2)
// ARB_MODE   0   0 = fixed priority (index 0 highest), 1 = round robin
// TIMEOUT    256 cycles with no s_ack before abort; 0 disables the timeout
// PORTS
// clk        in   1              clock, all state on rising edge
// rst        in   1              asynchronous, active-low reset
// m_req      in   N              per-master request
// m_addr     in   N*AW           per-master address, master i in slice [i*AW +: AW]
// m_burst    in   N*2            00 single, 01 INCR, 10 WRAP, 11 reserved (treated as single)
// m_wrb      in   N              1 = write, 0 = read
// m_wdata    in   N*DW           per-master write data
// m_bstrobe  in   N*DW/8         per-master byte strobes
// m_rdata    out  DW             read data, broadcast to all masters
// m_ack      out  N              per-master beat acknowledge
// m_stall    out  N              per-master stall
// m_err      out  N              one-cycle timeout-abort pulse
// grant      out  N              one-hot current owner; 0 when idle
// s_req/s_addr/s_burst/s_wrb/s_wdata/s_bstrobe  out  1/AW/2/1/DW/DW/8  slave-side request
// s_rdata/s_ack/s_stall                          in   DW/1/1            slave-side response
// BEHAVIOUR
// - Reset (rst=0), asynchronous:
//   - state=IDLE, grant=0, beat_cnt=0, timeout_cnt=0, rr_ptr=0.
//   - s_req=0, m_ack=0, m_err=0, m_stall=all 1s.
// - FSM states: IDLE, BUSY.
// - IDLE:
//   - If any m_req, the winner is picked combinationally.
//   - At the next edge: grant <= onehot(winner), beat_cnt <= 0, state <= BUSY.
//   - Arbitration latency is 1 cycle. No s_req is issued while in IDLE.
// - Winner selection:
//   - ARB_MODE=0: lowest index with m_req=1.
//   - ARB_MODE=1: first requester at or after rr_ptr, wrapping at N_MASTERS-1 -> 0.
//   - On grant to master i: rr_ptr <= (i+1) mod N_MASTERS.
// - BUSY (owner g):
//   - s_* = m_*[g] combinationally, including s_req = m_req[g].
//   - m_ack[g] = s_ack, m_stall[g] = s_stall, m_rdata = s_rdata.
//   - Every non-owner sees m_ack=0 and m_stall=1.
// - Beat counting: beat_cnt increments on each s_ack.
//   - Final beat is s_ack with beat_cnt == BURST_LEN-1 for INCR/WRAP; the first s_ack for single/11.
//   - m_burst[g] is sampled at grant and held in burst_q. A master changing BURST mid-transaction has no effect.
// - Completion: on the final-beat edge, state <= IDLE and grant <= 0.
//   - Consequence: one idle bubble cycle between back-to-back transactions.
// - Abort by master: m_req[g]==0 while BUSY -> IDLE at the next edge. No m_err.
//   - The slave sees s_req drop immediately.
// - Timeout (TIMEOUT>0):
//   - timeout_cnt clears at grant and on every s_ack, and increments otherwise in BUSY.
//   - When it reaches TIMEOUT-1 with no s_ack: m_err[g]=1 for exactly 1 cycle (registered), state <= IDLE, grant <= 0.
//   - The owner sees s_req drop the cycle after the err edge.
// - Simultaneous s_ack and timeout terminal count: the ack wins, the counter clears, no m_err.
// - Requests arriving while BUSY wait; no preemption, whatever the priority.
// - Reset mid-burst: everything returns to reset values immediately. The slave sees s_req=0 asynchronously.
// - s_stall never advances beat_cnt; only s_ack counts.
// - Widths: beat_cnt is $clog2(BURST_LEN) bits; timeout_cnt is $clog2(TIMEOUT+1) bits.
// STRUCTURE
// - Package cpu_bus_pkg:
//   - BURST_SINGLE/INCR/WRAP encodings.
//   - ARB_FIXED/ARB_RR constants.
//   - FSM state typedef (IDLE, BUSY).
// - Sub-module rr_arbiter: combinational picker.
//   - Inputs: req[N], ptr, mode. Output: one-hot win[N].
// - Top contains the FSM, counters and output muxes.
// TESTING
// - Fixed priority: m_req=2'b11, both single reads.
//   -> grant=01 first; s_ack -> IDLE bubble -> grant=10; m_ack pulses only on the owner.
// - Round robin, N=3: all three requesting continuously.
//   -> grant order 001, 010, 100, 001; rr_ptr wraps to 0.
// - INCR burst, BURST_LEN=4: s_stall=1 on beat 2 for 3 cycles.
//   -> exactly 4 m_ack, grant held through the stall, released after the 4th ack.
// - Timeout, TIMEOUT=8: s_ack held 0.
//   -> m_err[g] one-cycle pulse 8 cycles after grant, grant=0 next cycle, no m_ack.
// - Master abort: m_req[0] drops after beat 1 of 4.
//   -> s_req=0 same cycle, IDLE next edge, pending master 1 granted the following edge.
// - Async reset asserted mid-burst.
//   -> s_req=0, grant=0, m_stall all 1s without a clock edge; new arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared encodings and FSM state type for the CPU bus arbiter.
// Burst codes follow the core's BURST field; 2'b11 is reserved and handled as a single beat.
package cpu_bus_pkg;

  localparam logic [1:0] BURST_SINGLE = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_burst(input logic [1:0] b);
    logic r;
    case (b)
      BURST_INCR, BURST_WRAP: r = 1'b1;
      BURST_SINGLE:           r = 1'b0;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot picker: fixed priority (lowest index wins) or
// round robin starting at ptr and wrapping back to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  win
);

  logic found;

  // First pass covers [ptr, N-1] in round-robin mode; second pass wraps from 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && mode && req[i] && (i >= int'(ptr))) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Merges N CPU-side bus masters onto one memory-side port, holding the grant
// for a whole single-beat or BURST_LEN-beat transaction, with an optional bus timeout.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     m_req,
  input  logic [N_MASTERS*AW-1:0]  m_addr,
  input  logic [N_MASTERS*2-1:0]   m_burst,
  input  logic [N_MASTERS-1:0]     m_wrb,
  input  logic [N_MASTERS*DW-1:0]  m_wdata,
  input  logic [N_MASTERS*DW/8-1:0] m_bstrobe,
  output logic [DW-1:0]            m_rdata,
  output logic [N_MASTERS-1:0]     m_ack,
  output logic [N_MASTERS-1:0]     m_stall,
  output logic [N_MASTERS-1:0]     m_err,
  output logic [N_MASTERS-1:0]     grant,
  output logic                     s_req,
  output logic [AW-1:0]            s_addr,
  output logic [1:0]               s_burst,
  output logic                     s_wrb,
  output logic [DW-1:0]            s_wdata,
  output logic [DW/8-1:0]          s_bstrobe,
  input  logic [DW-1:0]            s_rdata,
  input  logic                     s_ack,
  input  logic                     s_stall
);

  localparam int SW = DW / 8;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = $clog2(N_MASTERS);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          TMO_EN    = (TIMEOUT > 0);
  localparam logic          RR_EN     = (ARB_MODE != ARB_FIXED);

  state_t               state_q, state_nxt;
  logic [N_MASTERS-1:0] grant_q;
  logic [N_MASTERS-1:0] err_q;
  logic [1:0]           burst_q;
  logic [BW-1:0]        beat_cnt;
  logic [TW-1:0]        timeout_cnt;
  logic [PW-1:0]        rr_ptr;

  logic [N_MASTERS-1:0] win;
  logic [PW-1:0]        ptr_nxt;
  logic [1:0]           win_burst;
  logic                 owner_req;
  logic                 final_beat;
  logic                 tmo_hit;

  rr_arbiter #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_arb (
    .req  (m_req),
    .ptr  (rr_ptr),
    .mode (RR_EN),
    .win  (win)
  );

  always_comb begin
    ptr_nxt   = '0;
    win_burst = BURST_SINGLE;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (win[i]) begin
        ptr_nxt   = (i == N_MASTERS - 1) ? '0 : PW'(i + 1);
        win_burst = m_burst[2*i +: 2];
      end
    end
  end

  always_comb begin
    owner_req  = |(grant_q & m_req);
    final_beat = s_ack && (!is_burst(burst_q) || (beat_cnt == BEAT_LAST));
    tmo_hit    = TMO_EN && !s_ack && (timeout_cnt == TMO_LAST);
    state_nxt  = state_q;
    case (state_q)
      IDLE:    if (|m_req) state_nxt = BUSY;
      BUSY:    if (!owner_req || final_beat || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A master dropping m_req aborts silently; only a timeout raises m_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      err_q       <= '0;
      burst_q     <= BURST_SINGLE;
      beat_cnt    <= '0;
      timeout_cnt <= '0;
      rr_ptr      <= '0;
    end else begin
      state_q <= state_nxt;
      err_q   <= '0;
      if (state_q == IDLE) begin
        if (|m_req) begin
          grant_q     <= win;
          burst_q     <= win_burst;
          beat_cnt    <= '0;
          timeout_cnt <= '0;
          rr_ptr      <= ptr_nxt;
        end
      end else if (state_nxt == IDLE) begin
        grant_q <= '0;
        if (owner_req && tmo_hit) err_q <= grant_q;
      end else if (s_ack) begin
        beat_cnt    <= beat_cnt + 1'b1;
        timeout_cnt <= '0;
      end else if (TMO_EN) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  // grant_q is zero outside BUSY, so the AND-OR muxes idle the slave port for free.
  always_comb begin
    s_addr    = '0;
    s_burst   = '0;
    s_wrb     = 1'b0;
    s_wdata   = '0;
    s_bstrobe = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_addr    = m_addr[i*AW +: AW];
        s_burst   = m_burst[2*i +: 2];
        s_wrb     = m_wrb[i];
        s_wdata   = m_wdata[i*DW +: DW];
        s_bstrobe = m_bstrobe[i*SW +: SW];
      end
    end
    s_req   = owner_req;
    m_ack   = grant_q & {N_MASTERS{s_ack}};
    m_stall = ~grant_q | {N_MASTERS{s_stall}};
    m_rdata = s_rdata;
    m_err   = err_q;
    grant   = grant_q;
  end

endmodule
